word_byte_serializer: RTL

- Downstream consumer of the 32-bit-to-byte split path.
- Accepts one 32-bit word per valid/ready handshake and emits its four bytes one per cycle on a byte-wide valid/ready stream.
- Byte order is MSB first by default: [31:24], [23:16], [15:8], [7:0].
- Feeds byte-wide sinks (UART TX, byte bus); supports back-to-back words with no bubble.

---
 rtl/word_byte_serializer_pkg.sv | 14 +
 rtl/word_byte_serializer.sv | 84 ++++++++
 2 files changed

// File: rtl/word_byte_serializer_pkg.sv
// Shared constants for the 32-bit word to byte split path.
// State encoding and widths used by the serializer and its upstream splitter.
package word_byte_serializer_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_e;

    localparam int BYTE_W = 8;
    localparam int IDX_W  = 2;
    localparam int WORD_W = 32;

endpackage

// File: rtl/word_byte_serializer.sv
// Serializes one word per valid/ready handshake into BYTES bytes on a byte stream.
// A last-byte handshake may accept the next word in the same cycle, so words stream with no bubble.
module word_byte_serializer
    import word_byte_serializer_pkg::*;
#(
    parameter int BYTES     = WORD_W / BYTE_W,
    parameter int MSB_FIRST = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [BYTE_W*BYTES-1:0]   in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [BYTE_W-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic [IDX_W-1:0]          out_idx
);

    localparam int                IN_W     = BYTE_W * BYTES;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    state_e                state_q;
    logic [IN_W-1:0]       word_q;
    logic [IDX_W-1:0]      idx_q;
    logic [BYTE_W-1:0]     data_q;
    logic                  valid_q;
    logic                  last_q;

    logic                  out_fire;
    logic                  last_fire;
    logic                  load;
    logic [IDX_W-1:0]      idx_d;

    // Emission position idx maps to a byte lane depending on the configured order.
    function automatic logic [BYTE_W-1:0] lane(input logic [IN_W-1:0] w,
                                               input logic [IDX_W-1:0] idx);
        logic [IN_W-1:0] sh;
        int              pos;
        pos = (MSB_FIRST != 0) ? (BYTES - 1 - int'(idx)) : int'(idx);
        sh  = w >> (BYTE_W * pos);
        return sh[BYTE_W-1:0];
    endfunction

    assign out_fire  = valid_q & out_ready;
    assign last_fire = out_fire & last_q;
    assign in_ready  = rst_n & ((state_q == S_IDLE) | last_fire);
    assign load      = in_valid & in_ready;
    assign idx_d     = idx_q + IDX_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (load) begin
            state_q <= S_SEND;
            word_q  <= in_data;
            idx_q   <= '0;
            data_q  <= lane(in_data, '0);
            valid_q <= 1'b1;
            last_q  <= (LAST_IDX == '0);
        end else if (last_fire) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (out_fire) begin
            idx_q   <= idx_d;
            data_q  <= lane(word_q, idx_d);
            last_q  <= (idx_d == LAST_IDX);
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign out_idx   = idx_q;

endmodule
